// File: rtl/rtc_alarm_bank.sv
// Multi-channel RTC alarm bank: prescaled free-running counter with NUM_CH match/auto-reload channels on APB.
// Optional capture input and CAP register at 0x24 when RTC_ALARM_CAPTURE_EN is defined.
module rtc_alarm_bank #(
    parameter int                     DATA_WIDTH  = 32,
    parameter int                     ADDR_WIDTH  = 12,
    parameter int                     NUM_CH      = 4,
    parameter int                     PRESC_WIDTH = 16,
    parameter logic [PRESC_WIDTH-1:0] PRESC_RESET = 16'd999
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic                  PSEL,
    input  logic                  PENABLE,
    input  logic                  PWRITE,
    input  logic [ADDR_WIDTH-1:0] PADDR,
    input  logic [DATA_WIDTH-1:0] PWDATA,
`ifdef RTC_ALARM_CAPTURE_EN
    input  logic                  cap_in,
    output logic [NUM_CH:0]       RTCINTR,
`else
    output logic [NUM_CH-1:0]     RTCINTR,
`endif
    output logic [DATA_WIDTH-1:0] PRDATA,
    output logic                  PREADY,
    output logic                  PSLVERR,
    output logic                  RTCINTR_ANY,
    output logic                  tick_out
);

`ifdef RTC_ALARM_CAPTURE_EN
    localparam int NI = NUM_CH + 1;
`else
    localparam int NI = NUM_CH;
`endif

    function automatic logic [7:0] ch_off(int i);
        return 8'(8'h40 + 8 * i);
    endfunction

    logic [7:0]                           off;
    logic                                 acc, wr, dec_ok;
    logic [DATA_WIDTH-1:0]                rdata;
    logic [DATA_WIDTH-1:0]                cnt, cnt_inc;
    logic [PRESC_WIDTH-1:0]               pcnt, presc;
    logic                                 en;
    logic [NUM_CH-1:0]                    chen, hit;
    logic [NI-1:0]                        imsc, ris, mis, set_v, icr_clr;
    logic [NUM_CH-1:0][DATA_WIDTH-1:0]    match_q, period_q;
    logic                                 tick, tick_eff, lr_wr, cr_wr, presc_wr;
    logic                                 unused_addr;

    assign off         = PADDR[7:0];
    assign unused_addr = ^PADDR[ADDR_WIDTH-1:8];
    assign acc         = PSEL & PENABLE;
    assign wr          = acc & PWRITE & dec_ok;
    assign lr_wr       = wr && off == 8'h04;
    assign cr_wr       = wr && off == 8'h08;
    assign presc_wr    = wr && off == 8'h0C;
    assign icr_clr     = (wr && off == 8'h20) ? PWDATA[NI-1:0] : '0;

    // A load on the same edge as a tick swallows that tick entirely.
    assign tick     = en & (pcnt == presc);
    assign tick_eff = tick & ~lr_wr;
    assign tick_out = tick_eff;
    assign cnt_inc  = cnt + 1'b1;

    always_comb begin
        rdata  = '0;
        dec_ok = 1'b1;
        case (off)
            8'h00: rdata = cnt;
            8'h04, 8'h20: rdata = '0;
            8'h08: rdata[0] = en;
            8'h0C: rdata[PRESC_WIDTH-1:0] = presc;
            8'h10: rdata[NUM_CH-1:0] = chen;
            8'h14: rdata[NI-1:0] = imsc;
            8'h18: rdata[NI-1:0] = ris;
            8'h1C: rdata[NI-1:0] = mis;
`ifdef RTC_ALARM_CAPTURE_EN
            8'h24: rdata = cap;
`endif
            default: begin
                dec_ok = 1'b0;
                for (int i = 0; i < NUM_CH; i++) begin
                    if (off == ch_off(i)) begin
                        dec_ok = 1'b1;
                        rdata  = match_q[i];
                    end
                    if (off == ch_off(i) + 8'd4) begin
                        dec_ok = 1'b1;
                        rdata  = period_q[i];
                    end
                end
            end
        endcase
    end

    assign PRDATA  = (PSEL & ~PWRITE) ? rdata : '0;
    assign PSLVERR = acc & ~dec_ok;
    assign PREADY  = 1'b1;

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            cnt   <= '0;
            pcnt  <= '0;
            presc <= PRESC_RESET;
            en    <= 1'b0;
            chen  <= '0;
            imsc  <= '0;
        end else begin
            if (lr_wr)         cnt <= PWDATA;
            else if (tick_eff) cnt <= cnt_inc;
            if (lr_wr | cr_wr | presc_wr) pcnt <= '0;
            else if (en)                  pcnt <= tick ? '0 : pcnt + 1'b1;
            if (cr_wr)             en    <= PWDATA[0];
            if (presc_wr)          presc <= PWDATA[PRESC_WIDTH-1:0];
            if (wr && off == 8'h10) chen <= PWDATA[NUM_CH-1:0];
            if (wr && off == 8'h14) imsc <= PWDATA[NI-1:0];
        end
    end

    // Match compares against the incremented value so RIS lands on the same edge as the count.
    always_comb begin
        hit = '0;
        for (int i = 0; i < NUM_CH; i++)
            hit[i] = tick_eff & chen[i] & (cnt_inc == match_q[i]);
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            match_q  <= '0;
            period_q <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (hit[i] && period_q[i] != '0)
                    match_q[i] <= match_q[i] + period_q[i];
                else if (wr && off == ch_off(i))
                    match_q[i] <= PWDATA;
                if (wr && off == ch_off(i) + 8'd4)
                    period_q[i] <= PWDATA;
            end
        end
    end

`ifdef RTC_ALARM_CAPTURE_EN
    logic                  cap_q, cap_prev;
    logic [DATA_WIDTH-1:0] cap;

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            cap_q    <= 1'b0;
            cap_prev <= 1'b0;
            cap      <= '0;
        end else begin
            cap_q    <= cap_in;
            cap_prev <= cap_q;
            if (cap_q & ~cap_prev) cap <= cnt;
        end
    end

    assign set_v = {cap_q & ~cap_prev, hit};
`else
    assign set_v = hit;
`endif

    // Set beats clear so an event landing on an ICR write is never lost.
    always_ff @(posedge PCLK) begin
        if (PRESET) ris <= '0;
        else        ris <= (ris & ~icr_clr) | set_v;
    end

    assign mis         = ris & imsc;
    assign RTCINTR     = mis;
    assign RTCINTR_ANY = |mis;

endmodule
